// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and data access (D).
// The winner's request is latched for the whole transaction; the response is routed only to the owner.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [STRB_W-1:0] d_req_strobe,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              m_req_valid,
    output logic              m_req_write,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [STRB_W-1:0] m_req_strobe,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant_d;

    // D wins when alone, or when both request and I was granted last.
    logic grant_d;
    logic grant_i;
    assign grant_d = d_req_valid && (!i_req_valid || !last_grant_d);
    assign grant_i = i_req_valid && !grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            m_req_valid  <= 1'b0;
            m_req_write  <= 1'b0;
            m_req_addr   <= '0;
            m_req_wdata  <= '0;
            m_req_strobe <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                        m_req_valid  <= 1'b1;
                        m_req_write  <= d_req_write;
                        m_req_addr   <= d_req_addr;
                        m_req_wdata  <= d_req_wdata;
                        m_req_strobe <= d_req_strobe;
                    end else if (grant_i) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                        m_req_valid  <= 1'b1;
                        m_req_write  <= 1'b0;
                        m_req_addr   <= i_req_addr;
                        m_req_wdata  <= '0;
                        m_req_strobe <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Single-beat completion always returns to IDLE for one cycle.
                    if (m_resp_valid) begin
                        state        <= IDLE;
                        m_req_valid  <= 1'b0;
                        m_req_write  <= 1'b0;
                        m_req_addr   <= '0;
                        m_req_wdata  <= '0;
                        m_req_strobe <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    m_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Response pass-through, gated so only the current owner ever sees it.
    assign i_resp_valid = (state == SERVE_I) && m_resp_valid;
    assign d_resp_valid = (state == SERVE_D) && m_resp_valid;
    assign i_resp_data  = i_resp_valid ? m_resp_data : '0;
    assign d_resp_data  = d_resp_valid ? m_resp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_req_valid = 1'b0;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    logic              d_req_valid = 1'b0;
    logic              d_req_write = 1'b0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [DATA_W-1:0] d_req_wdata = '0;
    logic [STRB_W-1:0] d_req_strobe = '0;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              m_req_valid;
    logic              m_req_write;
    logic [ADDR_W-1:0] m_req_addr;
    logic [DATA_W-1:0] m_req_wdata;
    logic [STRB_W-1:0] m_req_strobe;
    logic              m_resp_valid = 1'b0;
    logic [DATA_W-1:0] m_resp_data = '0;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_write  (d_req_write),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_strobe (d_req_strobe),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_write  (m_req_write),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_strobe (m_req_strobe),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and registered outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mvalid"}, 64'(m_req_valid), 64'd0);
        chk({tag, "_maddr"}, 64'(m_req_addr), 64'd0);
    endtask

    logic [63:0] exp_addr, exp_wdata, rdata;
    logic [7:0]  exp_strb;
    logic        exp_wr;
    logic        last_is_d, owner_d;
    int          cyc, w, grants_d, grants_i;

    initial begin
        // Reset state
        repeat (2) tick();
        check_idle("rst");
        chk("rst_mwrite", 64'(m_req_write), 64'd0);
        chk("rst_ivalid", 64'(i_resp_valid), 64'd0);
        chk("rst_dvalid", 64'(d_resp_valid), 64'd0);
        reset = 1'b0;
        tick();

        // Single D store with delayed completion
        d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 64'h8000_0010;
        d_req_wdata = 64'hDEAD_BEEF; d_req_strobe = 8'h0F;
        settle();
        chk("t1_no_comb_path", 64'(m_req_valid), 64'd0);
        tick();
        chk("t1_mvalid", 64'(m_req_valid), 64'd1);
        chk("t1_mwrite", 64'(m_req_write), 64'd1);
        chk("t1_maddr", m_req_addr, 64'h8000_0010);
        chk("t1_mwdata", m_req_wdata, 64'hDEAD_BEEF);
        chk("t1_mstrobe", 64'(m_req_strobe), 64'h0F);
        repeat (3) tick();
        chk("t1_hold_addr", m_req_addr, 64'h8000_0010);
        m_resp_valid = 1'b1; m_resp_data = 64'h0BAD_F00D;
        settle();
        chk("t1_dresp", 64'(d_resp_valid), 64'd1);
        chk("t1_ddata", d_resp_data, 64'h0BAD_F00D);
        chk("t1_iresp", 64'(i_resp_valid), 64'd0);
        tick();
        m_resp_valid = 1'b0; d_req_valid = 1'b0;
        settle();
        chk("t1_dresp_pulse", 64'(d_resp_valid), 64'd0);
        check_idle("t1_idle");

        // Simultaneous requests right after reset: D, then I, then D again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 64'h200;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 64'h100;
        d_req_wdata = 64'h55; d_req_strobe = 8'hFF;
        tick();
        chk("t2_first_d", m_req_addr, 64'h100);
        m_resp_valid = 1'b1; m_resp_data = 64'h1111;
        settle();
        chk("t2_dresp", 64'(d_resp_valid), 64'd1);
        chk("t2_iresp_quiet", 64'(i_resp_valid), 64'd0);
        tick();
        m_resp_valid = 1'b0; d_req_addr = 64'h108;
        settle();
        check_idle("t2_gap");
        tick();
        chk("t2_then_i", m_req_addr, 64'h200);
        chk("t2_i_write0", 64'(m_req_write), 64'd0);
        chk("t2_i_wdata0", m_req_wdata, 64'd0);
        chk("t2_i_strobe0", 64'(m_req_strobe), 64'd0);
        m_resp_valid = 1'b1; m_resp_data = 64'h2222;
        settle();
        chk("t2_iresp", 64'(i_resp_valid), 64'd1);
        chk("t2_idata", i_resp_data, 64'h2222);
        chk("t2_dresp_quiet", 64'(d_resp_valid), 64'd0);
        chk("t2_ddata_zero", d_resp_data, 64'd0);
        tick();
        m_resp_valid = 1'b0; i_req_valid = 1'b0;
        tick();
        chk("t2_d_again", m_req_addr, 64'h108);
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // No preemption while I owns the port
        i_req_valid = 1'b1; i_req_addr = 64'h8000_0000;
        tick();
        chk("t3_i_grant", m_req_addr, 64'h8000_0000);
        d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 64'h300;
        d_req_wdata = 64'h77; d_req_strobe = 8'hF0;
        repeat (2) tick();
        chk("t3_no_preempt", m_req_addr, 64'h8000_0000);
        chk("t3_no_preempt_wr", 64'(m_req_write), 64'd0);
        m_resp_valid = 1'b1; m_resp_data = 64'h3333;
        settle();
        chk("t3_iresp", 64'(i_resp_valid), 64'd1);
        tick();
        m_resp_valid = 1'b0; i_req_valid = 1'b0;
        settle();
        check_idle("t3_gap");
        tick();
        chk("t3_d_after", m_req_addr, 64'h300);
        chk("t3_d_strobe", 64'(m_req_strobe), 64'hF0);
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Stray completion while idle is ignored
        m_resp_valid = 1'b1; m_resp_data = 64'h1234;
        settle();
        chk("t4_iresp", 64'(i_resp_valid), 64'd0);
        chk("t4_dresp", 64'(d_resp_valid), 64'd0);
        chk("t4_idata", i_resp_data, 64'd0);
        tick();
        m_resp_valid = 1'b0;
        settle();
        check_idle("t4_still_idle");

        // Reset while D waits for its completion
        d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 64'h500;
        tick();
        chk("t5_d_serving", 64'(m_req_valid), 64'd1);
        reset = 1'b1; m_resp_valid = 1'b1;
        settle();
        check_idle("t5_async");
        chk("t5_mwrite", 64'(m_req_write), 64'd0);
        chk("t5_dresp", 64'(d_resp_valid), 64'd0);
        d_req_valid = 1'b0; m_resp_valid = 1'b0;
        tick();
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 64'h40;
        tick();
        chk("t5_i_grant", 64'(m_req_valid), 64'd1);
        chk("t5_i_addr", m_req_addr, 64'h40);
        m_resp_valid = 1'b1;
        tick();
        m_resp_valid = 1'b0; i_req_valid = 1'b0;

        // Random stream, both requesters always valid: model expects strict alternation starting with D
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_req_valid = 1'b1; i_req_addr = {$urandom, $urandom};
        d_req_valid = 1'b1; d_req_write = 1'($urandom); d_req_addr = {$urandom, $urandom};
        d_req_wdata = {$urandom, $urandom}; d_req_strobe = 8'($urandom);
        last_is_d = 1'b0; cyc = 0; grants_d = 0; grants_i = 0;
        while (cyc < 200) begin
            owner_d   = !last_is_d;
            exp_addr  = owner_d ? d_req_addr : i_req_addr;
            exp_wr    = owner_d ? d_req_write : 1'b0;
            exp_wdata = owner_d ? d_req_wdata : 64'd0;
            exp_strb  = owner_d ? d_req_strobe : 8'd0;
            tick(); cyc++;
            chk("rnd_mvalid", 64'(m_req_valid), 64'd1);
            chk("rnd_maddr", m_req_addr, exp_addr);
            chk("rnd_mwrite", 64'(m_req_write), 64'(exp_wr));
            chk("rnd_mwdata", m_req_wdata, exp_wdata);
            chk("rnd_mstrobe", 64'(m_req_strobe), 64'(exp_strb));
            w = $urandom_range(0, 3);
            repeat (w) begin
                tick(); cyc++;
                chk("rnd_hold_addr", m_req_addr, exp_addr);
                chk("rnd_hold_wdata", m_req_wdata, exp_wdata);
            end
            rdata = {$urandom, $urandom};
            m_resp_valid = 1'b1; m_resp_data = rdata;
            settle();
            chk("rnd_owner_valid", 64'(owner_d ? d_resp_valid : i_resp_valid), 64'd1);
            chk("rnd_owner_data", owner_d ? d_resp_data : i_resp_data, rdata);
            chk("rnd_other_valid", 64'(owner_d ? i_resp_valid : d_resp_valid), 64'd0);
            tick(); cyc++;
            m_resp_valid = 1'b0;
            if (owner_d) begin
                d_req_write = 1'($urandom); d_req_addr = {$urandom, $urandom};
                d_req_wdata = {$urandom, $urandom}; d_req_strobe = 8'($urandom);
                grants_d++;
            end else begin
                i_req_addr = {$urandom, $urandom};
                grants_i++;
            end
            settle();
            chk("rnd_gap", 64'(m_req_valid), 64'd0);
            last_is_d = owner_d;
        end
        chk("rnd_balance", 64'(grants_d - grants_i), 64'(last_is_d ? 1 : 0));
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
